note_scroller: RTL

Chart-driven note-field generator: the producer side of the 4-lane note interface that the hit-judgement logic consumes. It fetches chart rows from a read-only chart memory and scrolls them down a ROWS-deep 4-lane field, one row per beat tick. It drives `bottom_row` and `game_active` into the judgement block, and the full field to the display path. It sequences song start, pause, end-of-chart drain and completion.

---
 rtl/note_pkg.sv | 23 ++
 rtl/note_tick_gen.sv | 29 ++
 rtl/note_scroller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared constants and types for the chart-driven note-field producer.
package note_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned END_BIT = 4;
  localparam int unsigned ROM_W   = END_BIT + 1;
  localparam int unsigned UNDER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             end_mark;
    logic [ROW_W-1:0] lanes;
  } chart_row_t;

endpackage

// File: rtl/note_tick_gen.sv
// Scroll-tick divider: counts enabled, unpaused cycles and flags the last one.
module note_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pause,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is the final count of a period; the counter wraps on the same edge.
  assign tick = en && !pause && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !pause) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Fetches chart rows into a one-entry buffer and scrolls them down the note field.
module note_scroller
  import note_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic                  rom_rd,
  input  logic [ROM_W-1:0]      rom_data,
  input  logic                  rom_valid,
  output logic [LANES*ROWS-1:0] field,
  output logic [ROW_W-1:0]      bottom_row,
  output logic                  game_active,
  output logic                  song_done,
  output logic [UNDER_W-1:0]    underrun_cnt
);

  localparam int unsigned FIELD_W = LANES * ROWS;
  localparam int unsigned DRAIN_W = $clog2(ROWS);

  state_t               state, state_nxt;
  logic [FIELD_W-1:0]   field_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic                 rd_nxt;
  logic                 active_nxt;
  logic                 done_nxt;
  logic [UNDER_W-1:0]   under_nxt;
  chart_row_t           buf_row, buf_nxt;
  logic                 buf_full, buf_full_nxt;
  logic                 rd_pend, pend_nxt;
  logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
  chart_row_t           rom_row;
  logic                 valid_ok;
  logic                 tick;
  logic                 tick_en;
  logic                 tick_clr;
  logic                 do_shift;
  logic [ROW_W-1:0]     row_in;

  assign rom_row    = '{end_mark: rom_data[END_BIT], lanes: rom_data[ROW_W-1:0]};
  assign valid_ok   = rom_valid && rd_pend;
  assign tick_en    = (state == ST_RUN) || (state == ST_DRAIN);
  assign bottom_row = field[FIELD_W-1 -: ROW_W];

  note_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .pause (pause),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    field_nxt    = field;
    addr_nxt     = rom_addr;
    rd_nxt       = 1'b0;
    done_nxt     = 1'b0;
    under_nxt    = underrun_cnt;
    buf_nxt      = buf_row;
    buf_full_nxt = buf_full;
    pend_nxt     = rd_pend && !valid_ok;
    drain_nxt    = drain_cnt;
    tick_clr     = 1'b0;
    do_shift     = 1'b0;
    row_in       = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          field_nxt    = '0;
          addr_nxt     = '0;
          rd_nxt       = 1'b1;
          buf_full_nxt = 1'b0;
          state_nxt    = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (valid_ok) begin
          buf_nxt      = rom_row;
          buf_full_nxt = 1'b1;
          tick_clr     = 1'b1;
          state_nxt    = ST_RUN;
        end
      end
      ST_RUN: begin
        // The tick sees the buffer as it was; a same-cycle fetch lands afterwards.
        if (tick) begin
          do_shift = 1'b1;
          if (!buf_full) begin
            if (underrun_cnt != '1) begin
              under_nxt = underrun_cnt + UNDER_W'(1);
            end
          end else if (buf_row.end_mark) begin
            drain_nxt = DRAIN_W'(ROWS - 1);
            state_nxt = ST_DRAIN;
          end else begin
            row_in       = buf_row.lanes;
            buf_full_nxt = 1'b0;
            addr_nxt     = rom_addr + ADDR_W'(1);
            rd_nxt       = 1'b1;
          end
        end
        if (valid_ok) begin
          buf_nxt      = rom_row;
          buf_full_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tick) begin
          do_shift = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            drain_nxt = drain_cnt - DRAIN_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (do_shift) begin
      field_nxt = {field[FIELD_W-ROW_W-1:0], row_in};
    end
    if (rd_nxt) begin
      pend_nxt = 1'b1;
    end
    active_nxt = ((state_nxt == ST_RUN) || (state_nxt == ST_DRAIN)) && !pause;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      field        <= '0;
      rom_addr     <= '0;
      rom_rd       <= 1'b0;
      game_active  <= 1'b0;
      song_done    <= 1'b0;
      underrun_cnt <= '0;
      buf_row      <= '0;
      buf_full     <= 1'b0;
      rd_pend      <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      field        <= field_nxt;
      rom_addr     <= addr_nxt;
      rom_rd       <= rd_nxt;
      game_active  <= active_nxt;
      song_done    <= done_nxt;
      underrun_cnt <= under_nxt;
      buf_row      <= buf_nxt;
      buf_full     <= buf_full_nxt;
      rd_pend      <= pend_nxt;
      drain_cnt    <= drain_nxt;
    end
  end

endmodule
